tdm_demux16: RTL and testbench

Time-division demultiplexer that receives the serial slot stream produced by the team's 16:1 select-driven multiplexer tree and rebuilds the 16 parallel channel bits. It sits at the receive end of the TDM link. It locks to a frame-sync marker on slot 0, steers each accepted bit to its channel position, and presents a registered 16-bit word with a one-cycle valid strobe per completed frame.

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_slot_counter.sv | 30 +++
 rtl/tdm_demux16.sv | 120 ++++++++++++
 tb/tb_tdm_demux16.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM receive path.
package tdm_pkg;

    localparam int N_CH_DEF  = 16;
    localparam int SEL_W_DEF = 4;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: clear, load-to-1 and increment-with-wrap, plus a
// terminal-count flag marking the last slot of a frame.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load1,
    input  logic             clr,
    output logic [SEL_W-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == SEL_W'(N_CH - 1));

    // clr beats load1 beats en
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (load1)
            cnt <= SEL_W'(1);
        else if (en)
            cnt <= tc ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/tdm_demux16.sv
// TDM demultiplexer: locks to slot-0 sync, assembles N_CH serial bits, and
// publishes each full frame. Define TDM_DEMUX_SYNC_CHECK_EN to police sync in RUN.
module tdm_demux16
    import tdm_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_sync,
    output logic [N_CH-1:0]  out,
    output logic             out_valid,
    output logic [SEL_W-1:0] sel,
    output logic             locked,
    output logic             sync_err
);

    state_t            state_q, state_d;
    logic [N_CH-1:0]   shadow_q, word_nxt;
    logic [SEL_W-1:0]  wr_idx;
    logic              tc, store, ctr_en, ctr_load1, ctr_clr, done, err;

    tdm_slot_counter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctr_en),
        .load1 (ctr_load1),
        .clr   (ctr_clr),
        .cnt   (sel),
        .tc    (tc)
    );

    // A (re)sync always lands the bit in slot 0, whatever sel says.
    always_comb begin
        wr_idx           = ctr_load1 ? '0 : sel;
        word_nxt         = shadow_q;
        word_nxt[wr_idx] = in_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= HUNT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: if (in_valid && in_sync) state_d = RUN;
            RUN: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                if (in_valid && !in_sync && sel == '0) state_d = HUNT;
`endif
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        store     = 1'b0;
        ctr_en    = 1'b0;
        ctr_load1 = 1'b0;
        ctr_clr   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            HUNT: begin
                if (in_valid && in_sync) begin
                    store     = 1'b1;
                    ctr_load1 = 1'b1;
                end
            end
            RUN: begin
                if (in_valid) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                    if (in_sync && sel != '0) begin
                        // misplaced sync restarts the frame, even on the last slot
                        store     = 1'b1;
                        ctr_load1 = 1'b1;
                        err       = 1'b1;
                    end else if (!in_sync && sel == '0) begin
                        ctr_clr = 1'b1;
                        err     = 1'b1;
                    end else begin
                        store  = 1'b1;
                        ctr_en = 1'b1;
                        done   = tc;
                    end
`else
                    store  = 1'b1;
                    ctr_en = 1'b1;
                    done   = tc;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= done;
            sync_err  <= err;
            if (store) shadow_q <= word_nxt;
            if (done)  out      <= word_nxt;
        end
    end

    assign locked = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux16.sv
// Randomized scoreboard bench for tdm_demux16 against a slot-level frame model.
module tb_tdm_demux16;

    localparam int N  = 16;
    localparam int SW = 4;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, in_valid = 1'b0, in_bit = 1'b0, in_sync = 1'b0;
    logic [N-1:0]  out;
    logic          out_valid, locked, sync_err;
    logic [SW-1:0] sel;

    always #5 clk = ~clk;

    tdm_demux16 #(.N_CH(N), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_sync   (in_sync),
        .out       (out),
        .out_valid (out_valid),
        .sel       (sel),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    typedef struct {
        bit           ov;
        bit           err;
        int           slot;
        bit           lk;
        logic [N-1:0] word;
    } exp_t;

    exp_t         st_q[$];
    logic [N-1:0] frame_q[$];
    int           ov_times[$];
    int           n_cmp = 0, n_bad = 0, cyc_n = 0;

    // frame model: lock flag, next slot, collected bits, last published word
    bit           m_lk;
    int           m_slot;
    bit           m_bits[N];
    logic [N-1:0] m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input bit b, input bit s);
        exp_t e;
        e.ov = 0; e.err = 0;
        if (!r) begin
            m_lk = 0; m_slot = 0; m_out = '0;
            for (int i = 0; i < N; i++) m_bits[i] = 0;
        end else if (v) begin
            if (!m_lk) begin
                if (s) begin m_bits[0] = b; m_slot = 1; m_lk = 1; end
            end else if (CHK && s && m_slot != 0) begin
                e.err = 1; m_bits[0] = b; m_slot = 1;
            end else if (CHK && !s && m_slot == 0) begin
                e.err = 1; m_lk = 0; m_slot = 0;
            end else begin
                m_bits[m_slot] = b;
                if (m_slot == N - 1) begin
                    for (int i = 0; i < N; i++) m_out[i] = m_bits[i];
                    e.ov = 1;
                    frame_q.push_back(m_out);
                    m_slot = 0;
                end else m_slot++;
            end
        end
        e.slot = m_slot; e.lk = m_lk; e.word = m_out;
        st_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit v, input bit b, input bit s);
        @(negedge clk);
        rst_n = r; in_valid = v; in_bit = b; in_sync = s;
        model_step(r, v, b, s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 1'($urandom), 1'($urandom));
    endtask

    // one frame LSB-first, sync on slot 0, gaplen stall cycles after each slot in gapmask
    task automatic frame(input logic [N-1:0] w, input logic [N-1:0] gapmask, input int gaplen);
        for (int i = 0; i < N; i++) begin
            cyc(1, 1, w[i], i == 0);
            if (gapmask[i]) idle(gaplen);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // monitor: per-cycle status plus frame scoreboard on every out_valid
    exp_t mon_e;
    always @(posedge clk) begin
        cyc_n++;
        #1;
        if (st_q.size() > 0) begin
            mon_e = st_q.pop_front();
            chk("sel", 32'(sel), 32'(mon_e.slot));
            chk("locked", 32'(locked), 32'(mon_e.lk));
            chk("out_valid", 32'(out_valid), 32'(mon_e.ov));
            chk("sync_err", 32'(sync_err), 32'(mon_e.err));
            chk("out_hold", 32'(out), 32'(mon_e.word));
        end
        if (out_valid === 1'b1) begin
            ov_times.push_back(cyc_n);
            if (frame_q.size() == 0) chk("unexpected_frame", 32'(out), 32'hDEAD_BEEF);
            else chk("frame_word", 32'(out), 32'(frame_q.pop_front()));
        end
    end

    initial begin
        logic [N-1:0] w;
        int k;

        // reset
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 1);
        settle();
        chk("rst_out", 32'(out), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_sel", 32'(sel), 0);

        // contiguous A5C3
        frame(16'hA5C3, '0, 0);
        settle();
        chk("a5c3_out", 32'(out), 32'h0000_A5C3);
        chk("a5c3_locked", 32'(locked), 1);
        chk("a5c3_sel", 32'(sel), 0);

        // same frame with stalls after slots 4 and 11
        frame(16'hA5C3, 16'h0810, 3);
        settle();
        chk("gap_out", 32'(out), 32'h0000_A5C3);

        // back-to-back frames
        ov_times.delete();
        frame(16'h00FF, '0, 0);
        frame(16'h8001, '0, 0);
        settle();
        chk("b2b_count", 32'(ov_times.size()), 2);
        if (ov_times.size() == 2) chk("b2b_spacing", 32'(ov_times[1] - ov_times[0]), 16);
        chk("b2b_last", 32'(out), 32'h0000_8001);

        // misplaced sync at slot 5, then the 15 remaining bits of the new frame
        w = 16'h3C5A;
        for (int i = 0; i < 5; i++) cyc(1, 1, w[i], i == 0);
        for (int i = 0; i < N; i++) cyc(1, 1, w[i], i == 0);
        // next slot 0 without sync
        cyc(1, 1, 1, 0);
        idle(2);
        frame(16'h1234, '0, 0);

        // reset mid-frame at slot 9, then ignored non-sync bits
        for (int i = 0; i < 9; i++) cyc(1, 1, 1, i == 0);
        cyc(0, 1, 1, 0);
        settle();
        chk("midrst_out", 32'(out), 0);
        chk("midrst_locked", 32'(locked), 0);
        chk("midrst_sel", 32'(sel), 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0);
        settle();
        chk("hunt_ignores", 32'(locked), 0);
        frame(16'hBEEF, '0, 0);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 9);
            case (k)
                0: cyc(0, 1'($urandom), 1'($urandom), 1'($urandom));
                1: begin
                    for (int i = 0; i < int'($urandom_range(1, N - 1)); i++)
                        cyc(1, 1, 1'($urandom), i == 0);
                    frame(16'($urandom), '0, 0);
                end
                2: for (int i = 0; i < 20; i++)
                       cyc(1, 1'($urandom), 1'($urandom), $urandom_range(0, 11) == 0);
                default: frame(16'($urandom), 16'($urandom) & 16'($urandom), $urandom_range(1, 2));
            endcase
        end

        idle(3);
        settle();
        chk("status_drained", 32'(st_q.size()), 0);
        chk("frames_drained", 32'(frame_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
